// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: stall/flush/advance strobes, memory-wait and halt FSM, stall counter.
// Define PIPE_CTRL_FWD_EN to enable MEM/WB forwarding (only load-use then stalls).
module pipe_ctrl #(
    parameter int SCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic              id_rd_wr,
    input  logic              id_is_load,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              branch_taken_e,
    input  logic              mem_req_m,
    input  logic              mem_ack,
    input  logic              halt_req,
    input  logic              resume,
    output logic              if_adv,
    output logic              id_adv,
    output logic              ex_adv,
    output logic              mem_adv,
    output logic              wb_adv,
    output logic              id_ex_bubble,
    output logic              flush_if_id,
    output logic              inc_pc,
    output logic              branch_en,
    output logic              halted,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [SCNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rd_wr;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } slot_t;

    state_t state;
    slot_t  sl_ex, sl_mem, sl_wb;
    logic   halt_pend;
    logic   mem_stall, branch, hazard, hz1, hz2;
    logic [1:0] fwd_a, fwd_b;
    logic   unused_slot_bits;

    function automatic logic dep(input slot_t s, input logic [4:0] r);
        return s.valid && s.rd_wr && (r != 5'd0) && (s.rd == r);
    endfunction

`ifdef PIPE_CTRL_FWD_EN
    function automatic logic [1:0] fwd_pick(input logic [4:0] r, input slot_t m, input slot_t w);
        return dep(m, r) ? 2'd1 : (dep(w, r) ? 2'd2 : 2'd0);
    endfunction

    // Only a load still in EX cannot be bypassed.
    assign hz1   = sl_ex.is_load && dep(sl_ex, id_rs1);
    assign hz2   = sl_ex.is_load && dep(sl_ex, id_rs2);
    assign fwd_a = sl_ex.valid ? fwd_pick(sl_ex.rs1, sl_mem, sl_wb) : 2'd0;
    assign fwd_b = sl_ex.valid ? fwd_pick(sl_ex.rs2, sl_mem, sl_wb) : 2'd0;
`else
    assign hz1   = dep(sl_ex, id_rs1) || dep(sl_mem, id_rs1) || dep(sl_wb, id_rs1);
    assign hz2   = dep(sl_ex, id_rs2) || dep(sl_mem, id_rs2) || dep(sl_wb, id_rs2);
    assign fwd_a = 2'd0;
    assign fwd_b = 2'd0;
`endif

    // Some slot fields are only consumed in one build configuration.
    assign unused_slot_bits = ^{sl_ex, sl_mem, sl_wb};

    assign hazard = id_valid && ((id_uses_rs1 && hz1) || (id_uses_rs2 && hz2));
    assign branch = sl_ex.valid && branch_taken_e;
    assign mem_stall = (state == MEM_WAIT) ? !mem_ack
                     : ((state == RUN || state == DRAIN) && sl_mem.valid && mem_req_m && !mem_ack);

    always_comb begin
        if_adv       = 1'b0;
        id_adv       = 1'b0;
        ex_adv       = 1'b0;
        mem_adv      = 1'b0;
        wb_adv       = 1'b0;
        id_ex_bubble = 1'b0;
        flush_if_id  = 1'b0;
        inc_pc       = 1'b0;
        branch_en    = 1'b0;
        halted       = 1'b0;
        fwd_a_sel    = 2'd0;
        fwd_b_sel    = 2'd0;
        case (state)
            RUN, MEM_WAIT: begin
                if (!mem_stall) begin
                    {if_adv, id_adv, ex_adv, mem_adv, wb_adv} = 5'b11111;
                    if (branch) begin
                        branch_en    = 1'b1;
                        flush_if_id  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (hazard) begin
                        if_adv       = 1'b0;
                        id_adv       = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else begin
                        inc_pc = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!mem_stall) begin
                    {ex_adv, mem_adv, wb_adv} = 3'b111;
                    id_ex_bubble = 1'b1;
                end
            end
            default: halted = 1'b1;
        endcase
        if (state != HALTED) begin
            fwd_a_sel = fwd_a;
            fwd_b_sel = fwd_b;
        end
        if (!rst) begin
            {if_adv, id_adv, ex_adv, mem_adv, wb_adv} = 5'b00000;
            {id_ex_bubble, flush_if_id, inc_pc, branch_en, halted} = 5'b00000;
            fwd_a_sel = 2'd0;
            fwd_b_sel = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            halt_pend <= 1'b0;
            sl_ex     <= '0;
            sl_mem    <= '0;
            sl_wb     <= '0;
            stall_cnt <= '0;
        end else begin
            if (mem_adv) begin
                sl_wb  <= sl_mem;
                sl_mem <= sl_ex;
            end
            if (id_ex_bubble)
                sl_ex.valid <= 1'b0;
            else if (ex_adv)
                sl_ex <= '{valid: id_valid, rd: id_rd, rd_wr: id_rd_wr, is_load: id_is_load,
                           rs1: id_rs1, rs2: id_rs2};

            if (state != HALTED && (!id_adv || id_ex_bubble) && stall_cnt != {SCNT_W{1'b1}})
                stall_cnt <= stall_cnt + {{(SCNT_W-1){1'b0}}, 1'b1};

            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state <= MEM_WAIT;
                        if (halt_req) halt_pend <= 1'b1;
                    end else if (halt_req || halt_pend) begin
                        state     <= DRAIN;
                        halt_pend <= 1'b0;
                    end
                end
                MEM_WAIT: begin
                    if (halt_req) halt_pend <= 1'b1;
                    if (mem_ack) state <= RUN;
                end
                // The shift this cycle empties the pipe once EX and MEM are both invalid.
                DRAIN: if (!mem_stall && !sl_ex.valid && !sl_mem.valid) state <= HALTED;
                default: if (resume) state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; honours PIPE_CTRL_FWD_EN the same way as the design.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic id_valid, id_uses_rs1, id_uses_rs2, id_rd_wr, id_is_load;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic branch_taken_e, mem_req_m, mem_ack, halt_req, resume;
    logic if_adv, id_adv, ex_adv, mem_adv, wb_adv;
    logic id_ex_bubble, flush_if_id, inc_pc, branch_en, halted;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt;
    logic [9:0] ctl;
    int n = 0;
    int errs = 0;

    // {if,id,ex,mem,wb, bubble, flush, inc_pc, branch_en, halted}
    localparam logic [9:0] NORM  = 10'b11111_0_0_1_0_0;
    localparam logic [9:0] HZ    = 10'b00111_1_0_0_0_0;
    localparam logic [9:0] BR    = 10'b11111_1_1_0_1_0;
    localparam logic [9:0] DRN   = 10'b00111_1_0_0_0_0;
    localparam logic [9:0] HLT   = 10'b00000_0_0_0_0_1;
    localparam logic [9:0] ZERO  = 10'b0;

    assign ctl = {if_adv, id_adv, ex_adv, mem_adv, wb_adv, id_ex_bubble, flush_if_id, inc_pc, branch_en, halted};

    always #5 clk = ~clk;

    pipe_ctrl #(.SCNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd_wr(id_rd_wr), .id_is_load(id_is_load),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .branch_taken_e(branch_taken_e), .mem_req_m(mem_req_m), .mem_ack(mem_ack),
        .halt_req(halt_req), .resume(resume),
        .if_adv(if_adv), .id_adv(id_adv), .ex_adv(ex_adv), .mem_adv(mem_adv), .wb_adv(wb_adv),
        .id_ex_bubble(id_ex_bubble), .flush_if_id(flush_if_id), .inc_pc(inc_pc),
        .branch_en(branch_en), .halted(halted),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt)
    );

    task automatic idle_in();
        id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_rd_wr = 0; id_is_load = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        branch_taken_e = 0; mem_req_m = 0; mem_ack = 0; halt_req = 0; resume = 0;
    endtask

    task automatic id_op(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic ld);
        id_valid = 1; id_rd_wr = 1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_is_load = ld;
    endtask

    task automatic do_reset();
        rst = 0;
        idle_in();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_in();
        id_valid = 1; mem_ack = 1; resume = 1;
        @(negedge clk); #1;
        n++; if (ctl !== ZERO) begin errs++; $display("FAIL reset_ctl got %b want %b", ctl, ZERO); end
        n++; if (stall_cnt !== 16'd0) begin errs++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
        n++; if ({fwd_a_sel, fwd_b_sel} !== 4'd0) begin errs++; $display("FAIL reset_fwd got %b want 0000", {fwd_a_sel, fwd_b_sel}); end
        @(negedge clk);
        idle_in();
        rst = 1; #1;
        n++; if (ctl !== NORM) begin errs++; $display("FAIL reset_first got %b want %b", ctl, NORM); end
    endtask

    task automatic test_raw_alu();
        do_reset();
        @(negedge clk); id_op(5, 1, 2, 1, 1, 0); #1;
        n++; if (ctl !== NORM) begin errs++; $display("FAIL raw_c0 got %b want %b", ctl, NORM); end
        @(negedge clk); id_op(6, 5, 1, 1, 1, 0); #1;
`ifdef PIPE_CTRL_FWD_EN
        n++; if (ctl !== NORM) begin errs++; $display("FAIL raw_nostall got %b want %b", ctl, NORM); end
        @(negedge clk); idle_in(); #1;
        n++; if (fwd_a_sel !== 2'd1) begin errs++; $display("FAIL raw_fwd_a got %0d want 1", fwd_a_sel); end
        n++; if (fwd_b_sel !== 2'd0) begin errs++; $display("FAIL raw_fwd_b got %0d want 0", fwd_b_sel); end
        n++; if (stall_cnt !== 16'd0) begin errs++; $display("FAIL raw_cnt got %0d want 0", stall_cnt); end
`else
        for (int i = 0; i < 3; i++) begin
            if (i != 0) begin @(negedge clk); #1; end
            n++; if (ctl !== HZ) begin errs++; $display("FAIL raw_bubble%0d got %b want %b", i, ctl, HZ); end
        end
        @(negedge clk); #1;
        n++; if (ctl !== NORM) begin errs++; $display("FAIL raw_release got %b want %b", ctl, NORM); end
        n++; if (stall_cnt !== 16'd3) begin errs++; $display("FAIL raw_cnt got %0d want 3", stall_cnt); end
        @(negedge clk); idle_in(); #1;
        n++; if (fwd_a_sel !== 2'd0) begin errs++; $display("FAIL raw_fwd_a got %0d want 0", fwd_a_sel); end
`endif
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk); id_op(5, 2, 0, 1, 0, 1); #1;
        n++; if (ctl !== NORM) begin errs++; $display("FAIL lu_c0 got %b want %b", ctl, NORM); end
        @(negedge clk); id_op(6, 5, 0, 1, 1, 0); #1;
`ifdef PIPE_CTRL_FWD_EN
        n++; if (ctl !== HZ) begin errs++; $display("FAIL lu_bubble got %b want %b", ctl, HZ); end
        @(negedge clk); #1;
        n++; if (ctl !== NORM) begin errs++; $display("FAIL lu_release got %b want %b", ctl, NORM); end
        @(negedge clk); idle_in(); #1;
        n++; if (fwd_a_sel !== 2'd2) begin errs++; $display("FAIL lu_fwd_a got %0d want 2", fwd_a_sel); end
        n++; if (fwd_b_sel !== 2'd0) begin errs++; $display("FAIL lu_fwd_b got %0d want 0", fwd_b_sel); end
        n++; if (stall_cnt !== 16'd1) begin errs++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
`else
        for (int i = 0; i < 3; i++) begin
            if (i != 0) begin @(negedge clk); #1; end
            n++; if (ctl !== HZ) begin errs++; $display("FAIL lu_bubble%0d got %b want %b", i, ctl, HZ); end
        end
        @(negedge clk); #1;
        n++; if (ctl !== NORM) begin errs++; $display("FAIL lu_release got %b want %b", ctl, NORM); end
        n++; if (stall_cnt !== 16'd3) begin errs++; $display("FAIL lu_cnt got %0d want 3", stall_cnt); end
`endif
    endtask

    task automatic test_mem_wait();
        do_reset();
        @(negedge clk); id_op(7, 2, 0, 1, 0, 1); #1;
        n++; if (ctl !== NORM) begin errs++; $display("FAIL mw_c0 got %b want %b", ctl, NORM); end
        @(negedge clk); idle_in(); #1;
        n++; if (ctl !== NORM) begin errs++; $display("FAIL mw_c1 got %b want %b", ctl, NORM); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_req_m = 1; mem_ack = 0; halt_req = (i == 1); #1;
            n++; if (ctl !== ZERO) begin errs++; $display("FAIL mw_freeze%0d got %b want %b", i, ctl, ZERO); end
        end
        @(negedge clk); halt_req = 0; mem_ack = 1; #1;
        n++; if (ctl !== NORM) begin errs++; $display("FAIL mw_ack got %b want %b", ctl, NORM); end
        n++; if (stall_cnt !== 16'd4) begin errs++; $display("FAIL mw_cnt got %0d want 4", stall_cnt); end
        @(negedge clk); mem_req_m = 0; mem_ack = 0; #1;
        n++; if (ctl !== NORM) begin errs++; $display("FAIL mw_run got %b want %b", ctl, NORM); end
        n++; if (stall_cnt !== 16'd4) begin errs++; $display("FAIL mw_cnt2 got %0d want 4", stall_cnt); end
        @(negedge clk); #1;
        n++; if (ctl !== DRN) begin errs++; $display("FAIL mw_late_halt got %b want %b", ctl, DRN); end
        @(negedge clk); #1;
        n++; if (ctl !== HLT) begin errs++; $display("FAIL mw_halted got %b want %b", ctl, HLT); end
    endtask

    task automatic test_branch_hazard();
        do_reset();
        @(negedge clk); id_op(5, 2, 0, 1, 0, 1); #1;
        n++; if (ctl !== NORM) begin errs++; $display("FAIL br_c0 got %b want %b", ctl, NORM); end
        @(negedge clk); id_op(6, 5, 1, 1, 1, 0); branch_taken_e = 1; #1;
        n++; if (ctl !== BR) begin errs++; $display("FAIL br_taken got %b want %b", ctl, BR); end
        @(negedge clk); idle_in(); #1;
        n++; if (ctl !== NORM) begin errs++; $display("FAIL br_after got %b want %b", ctl, NORM); end
        n++; if (stall_cnt !== 16'd1) begin errs++; $display("FAIL br_cnt got %0d want 1", stall_cnt); end
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); id_op(i[4:0], 0, 0, 0, 0, 0); #1;
            n++; if (ctl !== NORM) begin errs++; $display("FAIL halt_fill%0d got %b want %b", i, ctl, NORM); end
        end
        @(negedge clk); idle_in(); halt_req = 1; #1;
        n++; if (ctl !== NORM) begin errs++; $display("FAIL halt_req got %b want %b", ctl, NORM); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); halt_req = 0; #1;
            n++; if (ctl !== DRN) begin errs++; $display("FAIL halt_drain%0d got %b want %b", i, ctl, DRN); end
        end
        @(negedge clk); #1;
        n++; if (ctl !== HLT) begin errs++; $display("FAIL halt_state got %b want %b", ctl, HLT); end
        n++; if (stall_cnt !== 16'd2) begin errs++; $display("FAIL halt_cnt got %0d want 2", stall_cnt); end
        @(negedge clk); resume = 1; #1;
        n++; if (ctl !== HLT) begin errs++; $display("FAIL halt_hold got %b want %b", ctl, HLT); end
        @(negedge clk); resume = 0; #1;
        n++; if (ctl !== NORM) begin errs++; $display("FAIL halt_resume got %b want %b", ctl, NORM); end
        n++; if (stall_cnt !== 16'd2) begin errs++; $display("FAIL halt_cnt_frozen got %0d want 2", stall_cnt); end
    endtask

    task automatic test_reset_midwait();
        do_reset();
        @(negedge clk); id_op(7, 2, 0, 1, 0, 1); #1;
        @(negedge clk); idle_in(); #1;
        @(negedge clk); mem_req_m = 1; #1;
        @(negedge clk); #1;
        n++; if (ctl !== ZERO) begin errs++; $display("FAIL rmw_wait got %b want %b", ctl, ZERO); end
        n++; if (stall_cnt !== 16'd1) begin errs++; $display("FAIL rmw_cnt got %0d want 1", stall_cnt); end
        #2; rst = 0; mem_ack = 1; #1;
        n++; if (ctl !== ZERO) begin errs++; $display("FAIL rmw_rst_ctl got %b want %b", ctl, ZERO); end
        n++; if (stall_cnt !== 16'd0) begin errs++; $display("FAIL rmw_rst_cnt got %0d want 0", stall_cnt); end
        @(negedge clk); idle_in(); rst = 1; #1;
        n++; if (ctl !== NORM) begin errs++; $display("FAIL rmw_release got %b want %b", ctl, NORM); end
    endtask

    initial begin
        test_reset();
        test_raw_alu();
        test_load_use();
        test_mem_wait();
        test_branch_hazard();
        test_halt();
        test_reset_midwait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, errs);
        $finish;
    end
endmodule
